dmem_responder: RTL

Data-memory responder for the CPU's data port: accepts read/write requests driven on `mem_rw`/`mem_aout`/`mem_dout` and returns read data on `mem_din`. Internally it holds a word-addressed RAM behind a request/acknowledge handshake with a programmable number of wait states. It sits at the top level beside the core and terminates the MEM stage's memory interface.

---
 rtl/dmem_responder.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data RAM behind a request/acknowledge
// handshake, with WAIT_CYCLES wait states between acceptance and commit.
// Optional feature macro: DMEM_BOUNDS_CHECK_EN (rejects misaligned and
// out-of-range byte addresses with mem_err). Without it, addresses alias
// modulo the RAM size and mem_err is tied low.

module dmem_responder #(
   parameter int ADDR_W      = 10,
   parameter int WAIT_CYCLES = 0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        mem_req,
   input  logic        mem_rw,
   input  logic [31:0] mem_aout,
   input  logic [31:0] mem_dout,
   output logic [31:0] mem_din,
   output logic        mem_ack,
   output logic        mem_err
);

   localparam int         DEPTH     = 1 << ADDR_W;
   localparam int         LOAD_I    = (WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0;
   localparam logic [3:0] CNT_LOAD  = LOAD_I[3:0];
   localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_nextState;
   logic [3:0]        r_count;

   logic              r_rw;
   logic [31:0]       r_addr;
   logic [31:0]       r_data;

   logic              w_accept;
   logic              w_commit;

   logic              w_cRw;
   logic [31:0]       w_cAddr;
   logic [31:0]       w_cData;
   logic [ADDR_W-1:0] w_cIdx;
   logic              w_cErr;
   logic              w_ramWe;

   logic [31:0]       r_din;
   logic [31:0]       r_mem [DEPTH];

   // With no wait states the request commits on its acceptance edge, so the
   // commit path must take the live bus; otherwise it uses the latched copy.
   assign w_cRw   = ZERO_WAIT ? mem_rw   : r_rw;
   assign w_cAddr = ZERO_WAIT ? mem_aout : r_addr;
   assign w_cData = ZERO_WAIT ? mem_dout : r_data;
   assign w_cIdx  = w_cAddr[ADDR_W+1:2];

`ifdef DMEM_BOUNDS_CHECK_EN
   logic r_errFlag;

   // Reject byte addresses that are misaligned or beyond the RAM.
   assign w_cErr = (w_cAddr[1:0] != 2'b00) || (w_cAddr[31:ADDR_W+2] != '0);
`else
   logic w_unusedAddrBits;

   // Byte-offset and upper address bits are deliberately ignored (aliasing).
   assign w_cErr           = 1'b0;
   assign w_unusedAddrBits = ^{w_cAddr[1:0], w_cAddr[31:ADDR_W+2]};
`endif

   // Reset is gated in so a request seen while reset is held never writes.
   assign w_ramWe = w_commit & w_cRw & ~w_cErr & ~reset;

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic plus the accept/commit strobes.
   always_comb begin
      w_nextState = r_state;
      w_accept    = 1'b0;
      w_commit    = 1'b0;
      case (r_state)
         ST_IDLE, ST_RESP: begin
            if (mem_req) begin
               w_accept = 1'b1;
               if (ZERO_WAIT) begin
                  w_commit    = 1'b1;
                  w_nextState = ST_RESP;
               end else begin
                  w_nextState = ST_WAIT;
               end
            end else begin
               w_nextState = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (r_count == 4'd0) begin
               w_commit    = 1'b1;
               w_nextState = ST_RESP;
            end
         end
         default: begin
            w_nextState = ST_IDLE;
         end
      endcase
   end

   // Wait-state counter: loads on acceptance, counts down, holds at zero.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_count <= 4'd0;
      end else if (w_accept) begin
         r_count <= CNT_LOAD;
      end else if ((r_state == ST_WAIT) && (r_count != 4'd0)) begin
         r_count <= r_count - 4'd1;
      end
   end

   // Capture the request on acceptance so mem_req/bus changes during WAIT are ignored.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_rw   <= 1'b0;
         r_addr <= 32'd0;
         r_data <= 32'd0;
      end else if (w_accept) begin
         r_rw   <= mem_rw;
         r_addr <= mem_aout;
         r_data <= mem_dout;
      end
   end

   // RAM write port; contents are not reset.
   always_ff @(posedge clock) begin
      if (w_ramWe) begin
         r_mem[w_cIdx] <= w_cData;
      end
   end

   // Read-data register: loaded only at commit and held until the next one.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_din <= 32'd0;
      end else if (w_commit) begin
         if (w_cErr) begin
            r_din <= 32'd0;
         end else if (w_cRw) begin
            r_din <= w_cData;
         end else begin
            r_din <= r_mem[w_cIdx];
         end
      end
   end

`ifdef DMEM_BOUNDS_CHECK_EN
   // Remember whether the committed request was rejected.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_errFlag <= 1'b0;
      end else if (w_commit) begin
         r_errFlag <= w_cErr;
      end
   end

   assign mem_err = mem_ack & r_errFlag;
`else
   assign mem_err = 1'b0;
`endif

   assign mem_ack = (r_state == ST_RESP);
   assign mem_din = r_din;

endmodule
